// File: rtl/maggie_seq_pkg.sv
// Shared types for the MAGGIE read sequencer: slot kinds, return tags and slot layout.
package maggie_seq_pkg;

  localparam int FONT_SLOT_OFS   = 8;
  localparam int SLOTS_PER_PIXEL = 16;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_LAYER = 2'd1,
    KIND_FONT  = 2'd2,
    KIND_HOST  = 2'd3
  } slot_kind_t;

  typedef struct packed {
    logic       valid;
    slot_kind_t kind;
    logic [2:0] idx;
  } tag_t;

endpackage

// File: rtl/maggie_seq_tag_pipe.sv
// Delay line that carries each issued read's tag alongside the fixed RAM latency.
module maggie_seq_tag_pipe
  import maggie_seq_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic clear,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/maggie_read_sequencer.sv
// Slot scheduler sharing the GPU RAM read port between MAGGIE layers and the host.
// Define GPU_SEQ_PERF_EN to add the idle_slots / host_wait saturating counters.
module maggie_read_sequencer
  import maggie_seq_pkg::*;
#(
  parameter int NUM_LAYERS      = 8,
  parameter int RAM_READ_CYCLES = 3,
  parameter int ADDR_W          = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               pc_ena_in,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  input  logic [NUM_LAYERS-1:0]    layer_en,
  input  logic [NUM_LAYERS-1:0]    layer_text,
  input  logic [NUM_LAYERS*4-1:0]  layer_font_row,
  input  logic [ADDR_W-1:0]        font_base,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [15:0]              ram_din,
  output logic [NUM_LAYERS*16-1:0] layer_data,
  output logic [NUM_LAYERS*8-1:0]  font_data,
  input  logic                     host_req,
  input  logic [ADDR_W-1:0]        host_addr,
  output logic                     host_ack,
  output logic [15:0]              host_data
`ifdef GPU_SEQ_PERF_EN
  ,
  output logic [15:0]              idle_slots,
  output logic [15:0]              host_wait
`endif
);

  // Layer inputs padded to 8 entries so slot indices never run off the end.
  logic [7:0]        en8;
  logic [7:0]        text8;
  logic [ADDR_W-1:0] laddr [8];
  logic [3:0]        row   [8];

  for (genvar k = 0; k < 8; k++) begin : g_pad
    if (k < NUM_LAYERS) begin : g_on
      assign en8[k]   = layer_en[k];
      assign text8[k] = layer_text[k];
      assign laddr[k] = layer_addr[k*ADDR_W +: ADDR_W];
      assign row[k]   = layer_font_row[k*4 +: 4];
    end else begin : g_off
      assign en8[k]   = 1'b0;
      assign text8[k] = 1'b0;
      assign laddr[k] = '0;
      assign row[k]   = '0;
    end
  end

  logic [2:0]        slot_idx;
  logic              layer_slot;
  logic              font_slot;
  logic              host_issue;
  logic              host_inflight;
  logic [ADDR_W-1:0] issue_addr;
  tag_t              issue_tag;
  tag_t              cap_tag;
  logic [15:0]       hold_layer [8];
  logic [7:0]        hold_font  [8];
  logic [7:0]        char_q     [8];

  assign slot_idx = pc_ena_in[2:0];

  always_comb begin
    layer_slot = !pc_ena_in[3] && en8[slot_idx];
    font_slot  = pc_ena_in[3] && en8[slot_idx] && text8[slot_idx];
    host_issue = !layer_slot && !font_slot && host_req && !host_inflight;
    issue_addr = ram_addr;
    issue_tag  = '0;
    if (layer_slot) begin
      issue_addr = laddr[slot_idx];
      issue_tag  = '{valid: 1'b1, kind: KIND_LAYER, idx: slot_idx};
    end else if (font_slot) begin
      issue_addr = font_base + ADDR_W'({char_q[slot_idx], row[slot_idx]});
      issue_tag  = '{valid: 1'b1, kind: KIND_FONT, idx: slot_idx};
    end else if (host_issue) begin
      issue_addr = host_addr;
      issue_tag  = '{valid: 1'b1, kind: KIND_HOST, idx: 3'd0};
    end
  end

  maggie_seq_tag_pipe #(
    .DEPTH (RAM_READ_CYCLES)
  ) u_tag_pipe (
    .clk     (clk),
    .clear   (reset),
    .tag_in  (issue_tag),
    .tag_out (cap_tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr      <= '0;
      host_ack      <= 1'b0;
      host_data     <= '0;
      host_inflight <= 1'b0;
      layer_data    <= '0;
      font_data     <= '0;
      for (int k = 0; k < 8; k++) begin
        hold_layer[k] <= '0;
        hold_font[k]  <= '0;
        char_q[k]     <= '0;
      end
    end else begin
      ram_addr <= issue_addr;
      host_ack <= 1'b0;
      if (host_issue) host_inflight <= 1'b1;
      if (cap_tag.valid) begin
        case (cap_tag.kind)
          KIND_LAYER: begin
            hold_layer[cap_tag.idx] <= ram_din;
            char_q[cap_tag.idx]     <= ram_din[7:0];
          end
          KIND_FONT: hold_font[cap_tag.idx] <= ram_din[7:0];
          KIND_HOST: begin
            host_data     <= ram_din;
            host_ack      <= 1'b1;
            host_inflight <= 1'b0;
          end
          default: ;
        endcase
      end
      // Holds at this phase form one complete pixel period; same-edge captures land next period.
      if (pc_ena_in == 4'(RAM_READ_CYCLES)) begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
          layer_data[k*16 +: 16] <= hold_layer[k];
          font_data[k*8 +: 8]    <= hold_font[k];
        end
      end
    end
  end

`ifdef GPU_SEQ_PERF_EN
  logic slot_idle;
  assign slot_idle = !layer_slot && !font_slot && !host_issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_slots <= '0;
      host_wait  <= '0;
    end else begin
      if (slot_idle && idle_slots != 16'hFFFF) idle_slots <= idle_slots + 16'd1;
      if (host_req && !host_issue && host_wait != 16'hFFFF) host_wait <= host_wait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_maggie_read_sequencer.sv
// Self-checking bench for maggie_read_sequencer: directed scenarios plus randomized traffic vs a slot-level model.
module tb_maggie_read_sequencer;

  localparam int NL = 8;
  localparam int RL = 3;
  localparam int AW = 20;

  logic            clk;
  logic            reset;
  logic [3:0]      pc_ena_in;
  logic [NL*AW-1:0] layer_addr;
  logic [NL-1:0]   layer_en;
  logic [NL-1:0]   layer_text;
  logic [NL*4-1:0] layer_font_row;
  logic [AW-1:0]   font_base;
  logic [AW-1:0]   ram_addr;
  logic [15:0]     ram_din;
  logic [NL*16-1:0] layer_data;
  logic [NL*8-1:0] font_data;
  logic            host_req;
  logic [AW-1:0]   host_addr;
  logic            host_ack;
  logic [15:0]     host_data;
`ifdef GPU_SEQ_PERF_EN
  logic [15:0]     idle_slots;
  logic [15:0]     host_wait;
`endif

  maggie_read_sequencer #(
    .NUM_LAYERS (NL), .RAM_READ_CYCLES (RL), .ADDR_W (AW)
  ) dut (
    .clk (clk), .reset (reset), .pc_ena_in (pc_ena_in),
    .layer_addr (layer_addr), .layer_en (layer_en), .layer_text (layer_text),
    .layer_font_row (layer_font_row), .font_base (font_base),
    .ram_addr (ram_addr), .ram_din (ram_din),
    .layer_data (layer_data), .font_data (font_data),
    .host_req (host_req), .host_addr (host_addr),
    .host_ack (host_ack), .host_data (host_data)
`ifdef GPU_SEQ_PERF_EN
    , .idle_slots (idle_slots), .host_wait (host_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pc_ena_in = 4'd0;
  always @(negedge clk) pc_ena_in <= pc_ena_in + 4'd1;

  // RAM returns addr[15:0], valid RL clks after the address is registered.
  logic [AW-1:0] ra1, ra2;
  always @(posedge clk) begin
    ra1 <= ram_addr;
    ra2 <= ra1;
  end
  assign ram_din = ra2[15:0];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: every issued read is queued with the edge on which its data is due.
  typedef struct {
    int          due;
    int          kind;
    int          idx;
    logic [AW-1:0] addr;
  } pend_t;

  pend_t         pend [$];
  logic [15:0]   m_hold [NL];
  logic [7:0]    m_font [NL];
  logic [7:0]    m_char [NL];
  bit            m_inflight;
  int            cyc;
  logic [AW-1:0] exp_ram_addr;
  logic          exp_host_ack;
  logic [15:0]   exp_host_data;
  logic [NL*16-1:0] exp_layer_data;
  logic [NL*8-1:0]  exp_font_data;
`ifdef GPU_SEQ_PERF_EN
  int            exp_idle;
  int            exp_wait;
`endif

  task automatic model_edge();
    int s, k, kind;
    bit iss, hiss;
    logic [AW-1:0] a;
    pend_t p;
    if (reset) begin
      pend.delete();
      m_inflight = 0;
      exp_ram_addr = '0; exp_host_ack = 0; exp_host_data = '0;
      exp_layer_data = '0; exp_font_data = '0;
      for (int j = 0; j < NL; j++) begin m_hold[j] = '0; m_font[j] = '0; m_char[j] = '0; end
`ifdef GPU_SEQ_PERF_EN
      exp_idle = 0; exp_wait = 0;
`endif
    end else begin
      s = int'(pc_ena_in);
      iss = 0; hiss = 0; kind = 0; k = 0; a = exp_ram_addr;
      if (s < 8) begin
        k = s;
        if (layer_en[k]) begin iss = 1; kind = 1; a = layer_addr[k*AW +: AW]; end
      end else begin
        k = s - 8;
        if (layer_en[k] && layer_text[k]) begin
          iss = 1; kind = 2;
          a = font_base + {8'h00, m_char[k], layer_font_row[k*4 +: 4]};
        end
      end
      if (!iss && host_req && !m_inflight) begin
        iss = 1; hiss = 1; kind = 3; k = 0; a = host_addr;
      end
`ifdef GPU_SEQ_PERF_EN
      if (!iss && exp_idle < 65535) exp_idle++;
      if (host_req && !hiss && exp_wait < 65535) exp_wait++;
`endif
      if (s == RL) begin
        for (int j = 0; j < NL; j++) begin
          exp_layer_data[j*16 +: 16] = m_hold[j];
          exp_font_data[j*8 +: 8]    = m_font[j];
        end
      end
      exp_host_ack = 0;
      while (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        case (p.kind)
          1: begin m_hold[p.idx] = p.addr[15:0]; m_char[p.idx] = p.addr[7:0]; end
          2: m_font[p.idx] = p.addr[7:0];
          default: begin exp_host_data = p.addr[15:0]; exp_host_ack = 1; m_inflight = 0; end
        endcase
      end
      if (iss) begin
        p.due = cyc + RL; p.kind = kind; p.idx = k; p.addr = a;
        pend.push_back(p);
        exp_ram_addr = a;
        if (hiss) m_inflight = 1;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_pc(input logic [3:0] v);
    int n;
    n = 0;
    step();
    while (pc_ena_in != v && n < 40) begin step(); n++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (ram_addr !== '0) begin n_errors++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
    n_checks++; if (host_ack !== 1'b0) begin n_errors++; $display("FAIL reset_host_ack: got %b want 0", host_ack); end
    n_checks++; if (host_data !== '0) begin n_errors++; $display("FAIL reset_host_data: got %h want 0", host_data); end
    n_checks++; if (layer_data !== '0) begin n_errors++; $display("FAIL reset_layer_data: got %h want 0", layer_data); end
    n_checks++; if (font_data !== '0) begin n_errors++; $display("FAIL reset_font_data: got %h want 0", font_data); end
    reset = 1'b0;
  endtask

  task automatic test_layer_read();
    layer_en = 8'h01; layer_text = '0;
    layer_addr[0 +: AW] = 20'h01234;
    wait_pc(4'd0);
    n_checks++; if (ram_addr !== 20'h01234) begin n_errors++; $display("FAIL layer_issue: ram_addr %h want %h", ram_addr, 20'h01234); end
    wait_pc(4'd3);
    wait_pc(4'd3);
    n_checks++; if (layer_data[15:0] !== 16'h1234) begin n_errors++; $display("FAIL layer_publish: layer_data[0] %h want 1234", layer_data[15:0]); end
    n_checks++; if (layer_data !== exp_layer_data) begin n_errors++; $display("FAIL layer_publish_all: %h want %h", layer_data, exp_layer_data); end
  endtask

  task automatic test_text_layer();
    layer_en = 8'h04; layer_text = 8'h04;
    layer_addr[2*AW +: AW] = 20'h00041;
    font_base = 20'h80000;
    layer_font_row[8 +: 4] = 4'd5;
    wait_pc(4'd2);
    wait_pc(4'd10);
    n_checks++; if (ram_addr !== 20'h80415) begin n_errors++; $display("FAIL font_issue: ram_addr %h want 80415", ram_addr); end
    wait_pc(4'd3);
    n_checks++; if (font_data[23:16] !== 8'h15) begin n_errors++; $display("FAIL font_publish: font_data[2] %h want 15", font_data[23:16]); end
    n_checks++; if (layer_data[47:32] !== 16'h0041) begin n_errors++; $display("FAIL char_publish: layer_data[2] %h want 0041", layer_data[47:32]); end
    n_checks++; if (font_data !== exp_font_data) begin n_errors++; $display("FAIL font_publish_all: %h want %h", font_data, exp_font_data); end
  endtask

  task automatic test_host_free_slot();
    layer_en = 8'h0F; layer_text = '0;
    for (int k = 0; k < NL; k++) layer_addr[k*AW +: AW] = 20'($urandom);
    wait_pc(4'd0);
    host_req = 1'b1; host_addr = 20'h00FF0;
    wait_pc(4'd4);
    n_checks++; if (ram_addr !== 20'h00FF0) begin n_errors++; $display("FAIL host_issue: ram_addr %h want 00ff0", ram_addr); end
    repeat (2) begin
      step();
      n_checks++; if (host_ack !== 1'b0) begin n_errors++; $display("FAIL host_ack_early: got %b want 0 at pc %0d", host_ack, pc_ena_in); end
    end
    step();
    n_checks++; if (host_ack !== 1'b1) begin n_errors++; $display("FAIL host_ack: got %b want 1", host_ack); end
    n_checks++; if (host_data !== 16'h0FF0) begin n_errors++; $display("FAIL host_data: got %h want 0ff0", host_data); end
    host_req = 1'b0;
    repeat (8) begin
      step();
      n_checks++; if (host_ack !== 1'b0) begin n_errors++; $display("FAIL host_double_issue: host_ack %b want 0 at pc %0d", host_ack, pc_ena_in); end
    end
  endtask

  task automatic test_disabled_layer();
    layer_en = 8'hFF; layer_text = '0;
    layer_addr[AW +: AW] = 20'h0BEEF;
    wait_pc(4'd1);
    wait_pc(4'd3);
    wait_pc(4'd3);
    n_checks++; if (layer_data[31:16] !== 16'hBEEF) begin n_errors++; $display("FAIL disabled_setup: layer_data[1] %h want beef", layer_data[31:16]); end
    wait_pc(4'd0);
    layer_en = 8'hFD; host_req = 1'b1; host_addr = 20'h0C0DE;
    step();
    n_checks++; if (ram_addr !== 20'h0C0DE) begin n_errors++; $display("FAIL slot1_to_host: ram_addr %h want 0c0de", ram_addr); end
    wait_pc(4'd4);
    n_checks++; if (host_ack !== 1'b1 || host_data !== 16'hC0DE) begin n_errors++; $display("FAIL slot1_host_ack: ack %b data %h want 1 c0de", host_ack, host_data); end
    host_req = 1'b0;
    repeat (2) begin
      wait_pc(4'd3);
      n_checks++; if (layer_data[31:16] !== 16'hBEEF) begin n_errors++; $display("FAIL disabled_hold: layer_data[1] %h want beef", layer_data[31:16]); end
    end
  endtask

  task automatic test_starvation();
    host_req = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    layer_en = 8'hFF; layer_text = 8'hFF;
    for (int k = 0; k < NL; k++) layer_addr[k*AW +: AW] = 20'($urandom);
    reset = 1'b0;
    host_req = 1'b1; host_addr = 20'h5A5A5;
    repeat (64) begin
      step();
      n_checks++; if (host_ack !== 1'b0) begin n_errors++; $display("FAIL starve_ack: host_ack %b want 0", host_ack); end
      n_checks++; if (ram_addr !== exp_ram_addr) begin n_errors++; $display("FAIL starve_addr: ram_addr %h want %h", ram_addr, exp_ram_addr); end
    end
`ifdef GPU_SEQ_PERF_EN
    n_checks++; if (host_wait !== 16'd64) begin n_errors++; $display("FAIL starve_host_wait: got %0d want 64", host_wait); end
    n_checks++; if (idle_slots !== 16'd0) begin n_errors++; $display("FAIL starve_idle: got %0d want 0", idle_slots); end
`endif
    host_req = 1'b0;
  endtask

  task automatic test_reset_midflight();
    layer_en = 8'h0F; layer_text = '0;
    repeat (20) step();
    wait_pc(4'd0);
    host_req = 1'b1; host_addr = 20'h0ABCD;
    wait_pc(4'd4);
    n_checks++; if (ram_addr !== 20'h0ABCD) begin n_errors++; $display("FAIL mid_issue: ram_addr %h want 0abcd", ram_addr); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (ram_addr !== '0 || host_ack !== 1'b0 || host_data !== '0) begin n_errors++; $display("FAIL mid_reset_out: addr %h ack %b data %h want 0", ram_addr, host_ack, host_data); end
    n_checks++; if (layer_data !== '0 || font_data !== '0) begin n_errors++; $display("FAIL mid_reset_pub: layer %h font %h want 0", layer_data, font_data); end
    step();
    n_checks++; if (ram_addr !== 20'h0ABCD) begin n_errors++; $display("FAIL mid_reissue: ram_addr %h want 0abcd", ram_addr); end
    repeat (2) begin
      step();
      n_checks++; if (host_ack !== 1'b0) begin n_errors++; $display("FAIL mid_stale_ack: host_ack %b want 0 at pc %0d", host_ack, pc_ena_in); end
    end
    step();
    n_checks++; if (host_ack !== 1'b1 || host_data !== 16'hABCD) begin n_errors++; $display("FAIL mid_reack: ack %b data %h want 1 abcd", host_ack, host_data); end
    host_req = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step();
      n_checks++; if (ram_addr !== exp_ram_addr) begin n_errors++; $display("FAIL rnd_ram_addr: %h want %h at cyc %0d", ram_addr, exp_ram_addr, cyc); end
      n_checks++; if (host_ack !== exp_host_ack) begin n_errors++; $display("FAIL rnd_host_ack: %b want %b at cyc %0d", host_ack, exp_host_ack, cyc); end
      n_checks++; if (host_data !== exp_host_data) begin n_errors++; $display("FAIL rnd_host_data: %h want %h at cyc %0d", host_data, exp_host_data, cyc); end
      n_checks++; if (layer_data !== exp_layer_data) begin n_errors++; $display("FAIL rnd_layer_data: %h want %h at cyc %0d", layer_data, exp_layer_data, cyc); end
      n_checks++; if (font_data !== exp_font_data) begin n_errors++; $display("FAIL rnd_font_data: %h want %h at cyc %0d", font_data, exp_font_data, cyc); end
`ifdef GPU_SEQ_PERF_EN
      n_checks++; if (idle_slots !== 16'(exp_idle) || host_wait !== 16'(exp_wait)) begin n_errors++; $display("FAIL rnd_perf: idle %0d wait %0d want %0d %0d", idle_slots, host_wait, exp_idle, exp_wait); end
`endif
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 11) == 0) begin
        layer_en   = 8'($urandom);
        layer_text = 8'($urandom);
        layer_font_row = 32'($urandom);
        font_base  = 20'($urandom);
        layer_addr[$urandom_range(0, NL-1)*AW +: AW] = 20'($urandom);
      end
      if (host_req && (host_ack || $urandom_range(0, 19) == 0)) host_req = 1'b0;
      else if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req = 1'b1; host_addr = 20'($urandom);
      end
    end
    reset = 1'b0; host_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; host_req = 1'b0; host_addr = '0;
    layer_addr = '0; layer_en = '0; layer_text = '0; layer_font_row = '0; font_base = '0;
    cyc = 0; m_inflight = 0;
    test_reset();
    test_layer_read();
    test_text_layer();
    test_host_free_slot();
    test_disabled_layer();
    test_starvation();
    test_reset_midflight();
    for (int k = 0; k < NL; k++) layer_addr[k*AW +: AW] = 20'($urandom);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
